// File: rtl/rf_write_arbiter_if.sv
// Signal bundle between the writeback-port arbiter, the EX/WB stage register
// and the multi-cycle side unit.
interface rf_write_arbiter_if;
  // Side-unit handshake: a write transfers on any rising edge where mc_req and
  // mc_ready are both 1; while mc_ready=0 the side unit holds mc_req/mc_rd/mc_data.
  logic       EX_WB_Reg_Write;
  logic [2:0] EX_WB_RD;
  logic [7:0] EX_WB_ALU_Result;
  logic       mc_req;
  logic [2:0] mc_rd;
  logic [7:0] mc_data;
  logic       mc_ready;
  logic       RF_Write_En;
  logic [2:0] RF_Write_Addr;
  logic [7:0] RF_Write_Data;
  logic [7:0] busy_mask;
  logic       stall_req;

  modport master (
    output EX_WB_Reg_Write, EX_WB_RD, EX_WB_ALU_Result, mc_req, mc_rd, mc_data,
    input  mc_ready, RF_Write_En, RF_Write_Addr, RF_Write_Data, busy_mask, stall_req
  );

  modport slave (
    input  EX_WB_Reg_Write, EX_WB_RD, EX_WB_ALU_Result, mc_req, mc_rd, mc_data,
    output mc_ready, RF_Write_En, RF_Write_Addr, RF_Write_Data, busy_mask, stall_req
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between the pipeline writeback (always
// wins) and an in-order queue of side-unit writes that drain into idle cycles.
module rf_write_arbiter #(
   parameter int DEPTH    = 4,
   parameter int MAX_WAIT = 4
) (
   input logic              Clk,
   input logic              Reset,
   rf_write_arbiter_if.slave bus
);

   localparam int PW = $clog2(DEPTH);
   localparam int WW = $clog2(MAX_WAIT + 1);
   localparam logic [PW:0]   LP_DEPTH = (PW + 1)'(DEPTH);
   localparam logic [WW-1:0] LP_MAX   = WW'(MAX_WAIT);

   logic [DEPTH-1:0] r_valid;
   logic [2:0]       r_rd   [DEPTH];
   logic [7:0]       r_data [DEPTH];
   logic [PW-1:0]    r_head;
   logic [PW-1:0]    r_tail;
   logic [PW:0]      r_count;
   logic [WW-1:0]    r_wait;
   logic             r_stall;

   logic             w_pipe;
   logic             w_nonempty;
   logic             w_full;
   logic             w_push;
   logic             w_pop;
   logic             w_head_valid;
   logic             w_head_cancel;
   logic [WW-1:0]    w_wait_nxt;
   logic [DEPTH-1:0] w_valid_nxt;
   logic [7:0]       w_busy;
   logic             w_en;
   logic [2:0]       w_addr;
   logic [7:0]       w_data;

   assign w_pipe        = bus.EX_WB_Reg_Write;
   assign w_nonempty    = (r_count != '0);
   assign w_full        = (r_count == LP_DEPTH);
   assign w_push        = bus.mc_req && !w_full;
   assign w_head_valid  = w_nonempty && r_valid[r_head];
   // An invalid (cancelled) head retires even while the pipeline owns the port.
   assign w_pop         = w_nonempty && (!r_valid[r_head] || !w_pipe);
   assign w_head_cancel = w_head_valid && w_pipe && (r_rd[r_head] == bus.EX_WB_RD);

   always_comb begin
      w_wait_nxt = '0;
      if (w_head_valid && w_pipe && !w_head_cancel)
         w_wait_nxt = (r_wait == LP_MAX) ? LP_MAX : r_wait + WW'(1);
   end

   // Cancel, then pop, then enqueue: the new entry is younger than the pipeline write.
   always_comb begin
      w_valid_nxt = r_valid;
      for (int i = 0; i < DEPTH; i++) begin
         if (w_pipe && r_valid[i] && (r_rd[i] == bus.EX_WB_RD))
            w_valid_nxt[i] = 1'b0;
      end
      if (w_pop)
         w_valid_nxt[r_head] = 1'b0;
      if (w_push)
         w_valid_nxt[r_tail] = 1'b1;
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_valid <= '0;
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_wait  <= '0;
         r_stall <= 1'b0;
      end else begin
         r_valid <= w_valid_nxt;
         r_wait  <= w_wait_nxt;
         r_stall <= (w_wait_nxt == LP_MAX);
         if (w_pop)
            r_head <= r_head + PW'(1);
         if (w_push)
            r_tail <= r_tail + PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (PW + 1)'(1);
            2'b01:   r_count <= r_count - (PW + 1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Payload storage needs no reset: every read is qualified by r_valid.
   always_ff @(posedge Clk) begin
      if (w_push) begin
         r_rd[r_tail]   <= bus.mc_rd;
         r_data[r_tail] <= bus.mc_data;
      end
   end

   always_comb begin
      w_busy = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (r_valid[i])
            w_busy[r_rd[i]] = 1'b1;
      end
   end

   always_comb begin
      w_en   = 1'b0;
      w_addr = '0;
      w_data = '0;
      if (Reset) begin
         if (w_pipe) begin
            w_en   = 1'b1;
            w_addr = bus.EX_WB_RD;
            w_data = bus.EX_WB_ALU_Result;
         end else if (w_head_valid) begin
            w_en   = 1'b1;
            w_addr = r_rd[r_head];
            w_data = r_data[r_head];
         end
      end
   end

   assign bus.mc_ready      = !w_full;
   assign bus.busy_mask     = w_busy;
   assign bus.stall_req     = r_stall;
   assign bus.RF_Write_En   = w_en;
   assign bus.RF_Write_Addr = w_addr;
   assign bus.RF_Write_Data = w_data;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed scenarios plus random traffic, every
// cycle compared against a queue-level model of the arbiter.
module tb_rf_write_arbiter;
  localparam int DEPTH    = 4;
  localparam int MAX_WAIT = 4;

  logic Clk   = 1'b0;
  logic Reset = 1'b0;
  always #5 Clk = ~Clk;

  rf_write_arbiter_if bus();

  rf_write_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  // Model entry: {valid, rd[2:0], data[7:0]}, oldest at index 0.
  logic [11:0] exp_q[$];
  int          m_wait;
  logic        m_stall;
  logic        last_accept;
  int          n_checks;
  int          n_fail;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [2:0] rd, input logic [7:0] data);
    bus.EX_WB_Reg_Write  = we;
    bus.EX_WB_RD         = rd;
    bus.EX_WB_ALU_Result = data;
  endtask

  task automatic side(input logic req, input logic [2:0] rd, input logic [7:0] data);
    bus.mc_req  = req;
    bus.mc_rd   = rd;
    bus.mc_data = data;
  endtask

  // One clock cycle: predict outputs, compare, then advance the model at the edge.
  task automatic step();
    logic [7:0] e_busy;
    logic       e_en;
    logic [2:0] e_addr;
    logic [7:0] e_data;
    logic       e_ready;
    logic       front_v;
    logic       pop;
    logic       pipe;
    logic [2:0] prd;
    if (!Reset) begin
      exp_q.delete();
      m_wait  = 0;
      m_stall = 1'b0;
    end
    pipe    = bus.EX_WB_Reg_Write;
    prd     = bus.EX_WB_RD;
    e_busy  = '0;
    foreach (exp_q[i]) if (exp_q[i][11]) e_busy[exp_q[i][10:8]] = 1'b1;
    e_ready = (exp_q.size() < DEPTH);
    front_v = (exp_q.size() > 0) && exp_q[0][11];
    e_en    = 1'b0;
    e_addr  = '0;
    e_data  = '0;
    if (Reset && pipe) begin
      e_en   = 1'b1;
      e_addr = prd;
      e_data = bus.EX_WB_ALU_Result;
    end else if (Reset && front_v) begin
      e_en   = 1'b1;
      e_addr = exp_q[0][10:8];
      e_data = exp_q[0][7:0];
    end
    #1;
    chk("rf_en",     bus.RF_Write_En,   e_en);
    chk("rf_addr",   bus.RF_Write_Addr, e_addr);
    chk("rf_data",   bus.RF_Write_Data, e_data);
    chk("mc_ready",  bus.mc_ready,      e_ready);
    chk("busy_mask", bus.busy_mask,     e_busy);
    chk("stall_req", bus.stall_req,     m_stall);
    last_accept = Reset && bus.mc_req && e_ready;
    @(posedge Clk);
    if (Reset) begin
      pop = (exp_q.size() > 0) && (!front_v || !pipe);
      if (pipe)
        foreach (exp_q[i]) if (exp_q[i][11] && exp_q[i][10:8] == prd) exp_q[i][11] = 1'b0;
      if (front_v && pipe && exp_q[0][11])
        m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT;
      else
        m_wait = 0;
      m_stall = (m_wait == MAX_WAIT);
      if (pop) void'(exp_q.pop_front());
      if (last_accept) exp_q.push_back({1'b1, bus.mc_rd, bus.mc_data});
    end
    @(negedge Clk);
  endtask

  logic [2:0] fill_rd [5];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_wait   = 0;
    m_stall  = 1'b0;
    last_accept = 1'b0;
    fill_rd = '{3'd5, 3'd6, 3'd1, 3'd4, 3'd7};
    drive(1'b0, 3'd0, 8'h00);
    side(1'b0, 3'd0, 8'h00);

    // Reset, then idle
    step();
    step();
    chk("rst_mc_ready", bus.mc_ready, 1);
    Reset = 1'b1;
    step();
    step();

    // Pipeline write with an empty queue
    drive(1'b1, 3'd3, 8'h5A);
    #1;
    chk("r3_en", bus.RF_Write_En, 1);
    chk("r3_addr", bus.RF_Write_Addr, 3);
    chk("r3_data", bus.RF_Write_Data, 8'h5A);
    step();
    drive(1'b0, 3'd0, 8'h00);

    // Single side write drains into the idle cycle
    side(1'b1, 3'd2, 8'h11);
    step();
    side(1'b0, 3'd0, 8'h00);
    #1;
    chk("r2_busy", bus.busy_mask, 8'h04);
    chk("r2_data", bus.RF_Write_Data, 8'h11);
    step();
    chk("r2_busy_clr", bus.busy_mask, 8'h00);

    // Fill the queue under a continuously writing pipeline
    drive(1'b1, 3'd0, 8'hC3);
    for (int k = 0; k < 4; k++) begin
      side(1'b1, fill_rd[k], 8'h30 + 8'(k));
      step();
      chk("fill_accept", last_accept, 1);
    end
    side(1'b1, fill_rd[4], 8'h34);
    for (int k = 0; k < 8; k++) begin
      step();
      chk("fifth_held", last_accept, 0);
    end
    chk("stall_set", bus.stall_req, 1);
    drive(1'b0, 3'd0, 8'h00);
    step();
    chk("stall_clr", bus.stall_req, 0);
    begin
      int guard = 0;
      while (!last_accept && guard < 10) begin
        step();
        guard++;
      end
      chk("fifth_accept", last_accept, 1);
    end
    side(1'b0, 3'd0, 8'h00);
    for (int k = 0; k < 8; k++) step();

    // Queued R4 superseded by a pipeline write to R4
    drive(1'b1, 3'd0, 8'h01);
    side(1'b1, 3'd4, 8'h22);
    step();
    side(1'b0, 3'd0, 8'h00);
    drive(1'b1, 3'd4, 8'h99);
    step();
    chk("cancel_busy", bus.busy_mask, 8'h00);
    drive(1'b0, 3'd0, 8'h00);
    step();
    step();

    // Reset with three writes queued
    drive(1'b1, 3'd0, 8'h02);
    for (int k = 0; k < 3; k++) begin
      side(1'b1, 3'(k + 1), 8'h40 + 8'(k));
      step();
    end
    side(1'b0, 3'd0, 8'h00);
    Reset = 1'b0;
    #1;
    chk("mid_rst_busy", bus.busy_mask, 8'h00);
    chk("mid_rst_en", bus.RF_Write_En, 0);
    chk("mid_rst_ready", bus.mc_ready, 1);
    step();
    Reset = 1'b1;
    drive(1'b0, 3'd0, 8'h00);
    for (int k = 0; k < 6; k++) step();

    // Random traffic with a side unit that holds its request until accepted
    for (int n = 0; n < 1500; n++) begin
      Reset = ($urandom_range(0, 199) != 0);
      drive($urandom_range(0, 99) < 60, 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
      if (!bus.mc_req && $urandom_range(0, 2) == 0)
        side(1'b1, 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
      step();
      if (last_accept) side(1'b0, 3'd0, 8'h00);
    end
    Reset = 1'b1;
    drive(1'b0, 3'd0, 8'h00);
    side(1'b0, 3'd0, 8'h00);
    for (int k = 0; k < 8; k++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Owns the single register-file write port in the writeback stage and shares it between two requesters:
  - the pipeline writeback, which comes from the EX/WB stage register;
  - a multi-cycle side unit, such as a serial multiplier or a load unit.
- Pipeline writes always win the port. Side-unit writes wait in a small in-order queue and drain into idle writeback cycles.
- When a pipeline write to the same register supersedes a queued write, the queued write is cancelled.
- The block reports which registers still have pending writes, and requests front-end stalls when a queued write starves.

Parameters:
- DEPTH, 4: queue entries; power of two, minimum 2.
- MAX_WAIT, 4: consecutive cycles a valid head entry may wait before stall_req rises; minimum 1.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- EX_WB_Reg_Write  in  1  pipeline writeback enable.
- EX_WB_RD  in  3  pipeline destination register.
- EX_WB_ALU_Result  in  8  pipeline write data.
- mc_req  in  1  side unit offers a write this cycle.
- mc_rd  in  3  side-unit destination register.
- mc_data  in  8  side-unit write data.
- mc_ready  out  1  queue can accept a write; equals !full.
- RF_Write_En  out  1  register-file write enable.
- RF_Write_Addr  out  3  register-file write address.
- RF_Write_Data  out  8  register-file write data.
- busy_mask  out  8  bit r is 1 while any valid queued entry targets register r.
- stall_req  out  1  request to the front-end to insert bubbles.

Behaviour:
- Reset:
  - Clock and reset behaviour is fixed: one clock; reset is asynchronous and active-low.
  - While Reset=0: queue is empty (head=tail=0, count=0, all valid bits 0), wait counter=0, stall_req=0.
  - While Reset=0 the outputs are: mc_ready=1, busy_mask=0, RF_Write_En=0, RF_Write_Addr=0, RF_Write_Data=0.
  - Reset asserted mid-operation discards every queued write; none of them is ever written.
- Queue structure: circular buffer of DEPTH slots, each holding {valid, rd, data}. count includes cancelled slots that have not yet been retired.
- Enqueue:
  - Accept condition: mc_req && mc_ready. The slot at tail is written with valid=1 at the clock edge.
  - The accepted entry becomes eligible from the next cycle. There is no same-cycle bypass.
  - mc_req while mc_ready=0 is ignored. The side unit holds mc_req, mc_rd and mc_data until it is accepted.
- Port mux (combinational):
  - If EX_WB_Reg_Write=1: the port carries EX_WB_RD and EX_WB_ALU_Result, with RF_Write_En=1.
  - Else if the head slot is valid and count>0: the port carries the head rd and data, with RF_Write_En=1. The head pops at the edge.
  - Otherwise RF_Write_En=0, and Addr and Data are driven to 0.
- Retire of a cancelled head: if the head is invalid and count>0, it pops at the edge without using the port. This happens even when the pipeline is writing.
- Cancellation:
  - When EX_WB_Reg_Write=1, every valid queued entry with rd==EX_WB_RD is cleared at the edge.
  - An entry enqueued in the same cycle is younger than the pipeline write and is not cancelled.
- Simultaneous enqueue and pop in one cycle: count is unchanged, and the pointers both advance modulo DEPTH.
- full means count==DEPTH.
- busy_mask: OR of the one-hot rd over all valid slots, derived from registered state. The decode stage uses it to stall on reads of pending registers.
- Starvation:
  - The wait counter increments on each cycle in which the head is valid and EX_WB_Reg_Write=1. It saturates at MAX_WAIT.
  - The counter clears when the head pops or is cancelled.
  - stall_req is registered: it becomes 1 on the edge where the counter reaches MAX_WAIT.
  - stall_req stays 1 until the edge on which the head drains or is cancelled, then returns to 0.
- Side-unit writes drain in program order. A cancelled entry never reaches the port.

Test Plan:
- Reset then idle -> mc_ready=1, busy_mask=0x00, RF_Write_En=0, stall_req=0.
- Pipeline writes R3=0x5A while the queue is empty -> same cycle: RF_Write_En=1, Addr=3, Data=0x5A.
- Enqueue R2=0x11 with the pipeline idle -> next cycle: busy_mask=0x04, port writes R2=0x11; the cycle after that: busy_mask=0x00.
- With the pipeline writing every cycle, enqueue R5, R6, R1, R4 -> after the 4th accept mc_ready=0 and a 5th mc_req is not accepted.
  - Stall check, same setup with the pipeline writing continuously: 4 cycles after R5 becomes eligible, stall_req=1.
  - Drop EX_WB_Reg_Write -> R5 drains, then stall_req=0.
- Queue holds R4=0x22 and the pipeline writes R4=0x99 -> the entry is cancelled and busy_mask bit 4 clears. The register file only ever sees R4=0x99; the slot retires without RF_Write_En.
- Assert Reset with 3 entries queued -> queue is empty immediately and no queued write appears after reset is released.
